// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the MM:SS.cc time-setting controller.
//   - state_t  : controller state encoding
//   - bcd60_t  : packed BCD value {tens[6:4], units[3:0]} in the range 00..59
//   - bcd60_valid / bcd60_fix / bcd60_inc / bcd60_dec : mod-60 BCD helpers
package rtc_pkg;

  localparam int BCD_W = 7;

  typedef logic [BCD_W-1:0] bcd60_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MIN = 2'd1,
    SET_SEC = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  // Blank masks for HEX5..HEX0: minutes live on HEX5/HEX4, seconds on HEX3/HEX2.
  localparam logic [5:0] HIDE_MIN = 6'b110000;
  localparam logic [5:0] HIDE_SEC = 6'b001100;

  function automatic logic bcd60_valid(input bcd60_t v);
    return (v[6:4] <= 3'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic bcd60_t bcd60_fix(input bcd60_t v);
    return bcd60_valid(v) ? v : '0;
  endfunction

  function automatic bcd60_t bcd60_inc(input bcd60_t v);
    if (!bcd60_valid(v) || v == 7'h59) return '0;
    if (v[3:0] == 4'd9) return {v[6:4] + 3'd1, 4'd0};
    return {v[6:4], v[3:0] + 4'd1};
  endfunction

  function automatic bcd60_t bcd60_dec(input bcd60_t v);
    if (!bcd60_valid(v)) return '0;
    if (v == 7'h00) return 7'h59;
    if (v[3:0] == 4'd0) return {v[6:4] - 3'd1, 4'd9};
    return {v[6:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/rtc_time_setter_key_debounce.sv
// key_debounce: synchronizer plus stability filter for one active-low button.
//   clk    : system clock
//   aclr   : asynchronous reset, active-high (debounced level resets to released)
//   key_n  : raw button, active-low, asynchronous to clk
//   press  : one-cycle pulse on an accepted released->pressed transition
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic aclr,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt is reloaded whenever the sample agrees with the accepted level, so it
  // only runs out after DEBOUNCE_CYC consecutive disagreeing samples.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= CW'(DEBOUNCE_CYC - 1);
      end else if (cnt == '0) begin
        level <= sync2;
        press <= ~sync2;
        cnt   <= CW'(DEBOUNCE_CYC - 1);
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/rtc_time_setter.sv
// rtc_time_setter: key-driven MM:SS editor for the real-time clock.
//   clk, aclr                     : system clock, async active-high reset
//   key_mode_n/key_inc_n/key_dec_n: raw active-low buttons
//   cur_min, cur_sec              : running time (packed BCD), captured on edit entry
//   set_min, set_sec              : edited time (packed BCD), valid while load=1
//   load                          : one-cycle strobe, clock takes set_* and clears cc
//   run_en                        : clock count enable, low while editing
//   editing                       : high in SET_MIN / SET_SEC
//   hide                          : per-digit blank mask for HEX5..HEX0
//
// state   | meaning
// --------+---------------------------------------------------
// RUN     | clock running, inc/dec ignored
// SET_MIN | editing minutes, minute digits blink
// SET_SEC | editing seconds, second digits blink
// COMMIT  | one cycle, load strobe to the clock, then RUN
module rtc_time_setter
  import rtc_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int BLINK_CYC    = 12_500_000,
  parameter int TIMEOUT_CYC  = 500_000_000
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         key_mode_n,
  input  logic         key_inc_n,
  input  logic         key_dec_n,
  input  logic [6:0]   cur_min,
  input  logic [6:0]   cur_sec,
  output logic [6:0]   set_min,
  output logic [6:0]   set_sec,
  output logic         load,
  output logic         run_en,
  output logic         editing,
  output logic [5:0]   hide
);

  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_CYC + 1);

  logic ev_mode, ev_inc, ev_dec;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk(clk), .aclr(aclr), .key_n(key_mode_n), .press(ev_mode));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk(clk), .aclr(aclr), .key_n(key_inc_n), .press(ev_inc));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dec (
    .clk(clk), .aclr(aclr), .key_n(key_dec_n), .press(ev_dec));

  state_t        state, state_nxt;
  bcd60_t        min_nxt, sec_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic [BW-1:0] blink_cnt, blink_nxt;
  logic          phase, phase_nxt;
  logic          any_ev, step_inc, step_dec;
  logic          edit_now, edit_nxt, timeout;

  always_comb begin
    any_ev   = ev_mode | ev_inc | ev_dec;
    // inc and dec landing together cancel each other
    step_inc = ev_inc & ~ev_dec;
    step_dec = ev_dec & ~ev_inc;
    edit_now = (state == SET_MIN) || (state == SET_SEC);
    timeout  = edit_now && (idle_cnt == '0) && !any_ev;

    state_nxt = state;
    min_nxt   = set_min;
    sec_nxt   = set_sec;

    case (state)
      RUN: begin
        if (ev_mode) begin
          state_nxt = SET_MIN;
          min_nxt   = bcd60_fix(cur_min);
          sec_nxt   = bcd60_fix(cur_sec);
        end
      end
      SET_MIN: begin
        if (ev_mode)       state_nxt = SET_SEC;
        else if (timeout)  state_nxt = RUN;
        else if (step_inc) min_nxt   = bcd60_inc(set_min);
        else if (step_dec) min_nxt   = bcd60_dec(set_min);
      end
      SET_SEC: begin
        if (ev_mode)       state_nxt = COMMIT;
        else if (timeout)  state_nxt = RUN;
        else if (step_inc) sec_nxt   = bcd60_inc(set_sec);
        else if (step_dec) sec_nxt   = bcd60_dec(set_sec);
      end
      default: state_nxt = RUN;
    endcase

    edit_nxt = (state_nxt == SET_MIN) || (state_nxt == SET_SEC);

    // Idle timer only runs while staying in an edit state with no key activity.
    if (edit_now && edit_nxt && !any_ev) idle_nxt = idle_cnt - IW'(1);
    else                                 idle_nxt = IW'(TIMEOUT_CYC - 1);

    // Blink phase restarts at 0 on edit entry and keeps running across fields.
    phase_nxt = 1'b0;
    blink_nxt = BW'(BLINK_CYC - 1);
    if (edit_now && edit_nxt) begin
      if (blink_cnt == '0) begin
        phase_nxt = ~phase;
      end else begin
        phase_nxt = phase;
        blink_nxt = blink_cnt - BW'(1);
      end
    end
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state     <= RUN;
      set_min   <= '0;
      set_sec   <= '0;
      idle_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      load      <= 1'b0;
      run_en    <= 1'b1;
      editing   <= 1'b0;
      hide      <= '0;
    end else begin
      state     <= state_nxt;
      set_min   <= min_nxt;
      set_sec   <= sec_nxt;
      idle_cnt  <= idle_nxt;
      blink_cnt <= blink_nxt;
      phase     <= phase_nxt;
      load      <= (state_nxt == COMMIT);
      run_en    <= (state_nxt == RUN) || (state_nxt == COMMIT);
      editing   <= edit_nxt;
      if (state_nxt == SET_MIN && phase_nxt)      hide <= HIDE_MIN;
      else if (state_nxt == SET_SEC && phase_nxt) hide <= HIDE_SEC;
      else                                        hide <= '0;
    end
  end

endmodule

// File: tb/tb_rtc_time_setter.sv
// Testbench for rtc_time_setter with short debounce/blink/timeout settings.
module tb_rtc_time_setter;

  logic       clk = 1'b0;
  logic       aclr = 1'b1;
  logic       key_mode_n = 1'b1;
  logic       key_inc_n = 1'b1;
  logic       key_dec_n = 1'b1;
  logic [6:0] cur_min = 7'h00;
  logic [6:0] cur_sec = 7'h00;
  logic [6:0] set_min, set_sec;
  logic       load, run_en, editing;
  logic [5:0] hide;

  rtc_time_setter #(.DEBOUNCE_CYC(4), .BLINK_CYC(8), .TIMEOUT_CYC(200)) dut (
    .clk(clk), .aclr(aclr),
    .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
    .cur_min(cur_min), .cur_sec(cur_sec),
    .set_min(set_min), .set_sec(set_sec),
    .load(load), .run_en(run_en), .editing(editing), .hide(hide));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // reference model: 0 = running, 1 = editing minutes, 2 = editing seconds
  int m_st = 0;
  int m_min = 0;
  int m_sec = 0;
  int exp_loads = 0;
  int exp_ld_min = 0;
  int exp_ld_sec = 0;

  int act_loads = 0;
  logic [6:0] ld_min = 7'h00;
  logic [6:0] ld_sec = 7'h00;

  always @(posedge clk) begin
    if (load === 1'b1) begin
      act_loads++;
      ld_min = set_min;
      ld_sec = set_sec;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] to_bcd(input int v);
    return 7'(((v / 10) << 4) + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [6:0] b);
    int t, u;
    t = int'(b) / 16;
    u = int'(b) % 16;
    if (t > 5 || u > 9) return 0;
    return t * 10 + u;
  endfunction

  function automatic logic [6:0] rand_bcd();
    if ($urandom_range(0, 3) != 0) return to_bcd(int'($urandom_range(0, 59)));
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic model_ev(input logic m, input logic i, input logic d);
    if (m) begin
      case (m_st)
        0: begin m_st = 1; m_min = from_bcd(cur_min); m_sec = from_bcd(cur_sec); end
        1: m_st = 2;
        default: begin
          m_st = 0;
          exp_loads++;
          exp_ld_min = m_min;
          exp_ld_sec = m_sec;
        end
      endcase
    end else if (i && d) begin
      // cancel
    end else if (m_st == 1) begin
      m_min = i ? (m_min + 1) % 60 : (m_min + 59) % 60;
    end else if (m_st == 2) begin
      m_sec = i ? (m_sec + 1) % 60 : (m_sec + 59) % 60;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".editing"}, 32'(editing), 32'(m_st != 0));
    chk({tag, ".run_en"}, 32'(run_en), 32'(m_st == 0));
    chk({tag, ".set_min"}, 32'(set_min), 32'(to_bcd(m_min)));
    chk({tag, ".set_sec"}, 32'(set_sec), 32'(to_bcd(m_sec)));
    chk({tag, ".loads"}, 32'(act_loads), 32'(exp_loads));
    chk({tag, ".ld_min"}, 32'(ld_min), 32'(to_bcd(exp_ld_min)));
    chk({tag, ".ld_sec"}, 32'(ld_sec), 32'(to_bcd(exp_ld_sec)));
    chk({tag, ".load"}, 32'(load), 32'd0);
    if (m_st == 0) chk({tag, ".hide"}, 32'(hide), 32'd0);
  endtask

  task automatic press(input string tag, input logic m, input logic i, input logic d);
    @(negedge clk);
    key_mode_n = ~m;
    key_inc_n  = ~i;
    key_dec_n  = ~d;
    model_ev(m, i, d);
    repeat (10) @(negedge clk);
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    key_dec_n  = 1'b1;
    repeat (10) @(negedge clk);
    check_all(tag);
  endtask

  task automatic blink_win(input string tag, input logic [5:0] mask);
    int on_cnt = 0;
    int bad = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (hide == mask) on_cnt++;
      else if (hide != 6'd0) bad++;
    end
    chk({tag, ".on"}, 32'(on_cnt), 32'd16);
    chk({tag, ".other"}, 32'(bad), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".editing"}, 32'(editing), 32'd0);
    chk({tag, ".run_en"}, 32'(run_en), 32'd1);
    chk({tag, ".load"}, 32'(load), 32'd0);
    chk({tag, ".hide"}, 32'(hide), 32'd0);
    chk({tag, ".set_min"}, 32'(set_min), 32'd0);
    chk({tag, ".set_sec"}, 32'(set_sec), 32'd0);
  endtask

  initial begin
    logic [2:0] combo;

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    aclr = 1'b0;
    repeat (3) @(negedge clk);
    check_all("idle");

    // full edit 12:34 -> 00:33
    cur_min = 7'h12; cur_sec = 7'h34;
    press("enter", 1, 0, 0);
    chk("cap_min", 32'(set_min), 32'h12);
    blink_win("blink_min", 6'b110000);
    for (int k = 0; k < 48; k++) press("inc48", 0, 1, 0);
    chk("wrap59", 32'(set_min), 32'h00);
    press("to_sec", 1, 0, 0);
    blink_win("blink_sec", 6'b001100);
    press("dec1", 0, 0, 1);
    chk("sec33", 32'(set_sec), 32'h33);
    press("commit", 1, 0, 0);
    chk("ld_cnt1", 32'(act_loads), 32'd1);
    chk("ld_val", 32'({ld_min, ld_sec}), 32'({7'h00, 7'h33}));

    // BCD carry / borrow / wrap in seconds
    cur_min = 7'h00; cur_sec = 7'h09;
    press("w_enter", 1, 0, 0);
    press("w_sec", 1, 0, 0);
    press("w_inc09", 0, 1, 0);
    chk("carry10", 32'(set_sec), 32'h10);
    press("w_dec10", 0, 0, 1);
    chk("borrow09", 32'(set_sec), 32'h09);
    for (int k = 0; k < 9; k++) press("w_down", 0, 0, 1);
    press("w_dec00", 0, 0, 1);
    chk("wrap00", 32'(set_sec), 32'h59);
    press("w_commit", 1, 0, 0);

    // timeout: no load, back to running
    cur_min = 7'h05; cur_sec = 7'h05;
    press("t_enter", 1, 0, 0);
    repeat (150) @(negedge clk);
    chk("t_early", 32'(editing), 32'd1);
    repeat (60) @(negedge clk);
    m_st = 0;
    check_all("t_expired");

    // bounce on inc while editing minutes
    cur_min = 7'h20; cur_sec = 7'h20;
    press("b_enter", 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      key_inc_n = (k % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    key_inc_n = 1'b1;
    repeat (10) @(negedge clk);
    check_all("bounce");
    press("b_hold", 0, 1, 0);
    chk("b_plus1", 32'(set_min), 32'h21);
    press("b_sec", 1, 0, 0);
    press("b_commit", 1, 0, 0);

    // collisions
    cur_min = 7'h30; cur_sec = 7'h30;
    press("c_enter", 1, 0, 0);
    press("c_incdec", 0, 1, 1);
    chk("c_same", 32'(set_min), 32'h30);
    press("c_modeinc", 1, 1, 0);
    chk("c_sec", 32'(editing), 32'd1);
    chk("c_min_kept", 32'(set_min), 32'h30);
    press("c_incdec2", 0, 1, 1);
    press("c_commit", 1, 0, 0);

    // invalid capture
    cur_min = 7'h45; cur_sec = 7'h6A;
    press("i_enter", 1, 0, 0);
    chk("i_sec00", 32'(set_sec), 32'h00);
    chk("i_min45", 32'(set_min), 32'h45);
    press("i_sec", 1, 0, 0);
    press("i_commit", 1, 0, 0);

    // randomized key traffic
    for (int n = 0; n < 60; n++) begin
      cur_min = rand_bcd();
      cur_sec = rand_bcd();
      combo = 3'($urandom_range(1, 7));
      press("rnd", combo[2], combo[1], combo[0]);
    end

    // reset mid-edit
    if (m_st == 0) press("r_enter", 1, 0, 0);
    press("r_inc", 0, 1, 0);
    @(negedge clk);
    aclr = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("mid_rst");
    aclr = 1'b0;
    m_st = 0; m_min = 0; m_sec = 0;
    repeat (5) @(negedge clk);
    check_all("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_time_setter.md
# rtc_time_setter

Key-driven time-setting controller for the MM:SS.cc real-time clock: the writer side of the clock's asynchronous-load interface. It debounces three push-buttons and snapshots the running time when edit mode is entered. It edits minutes and seconds as BCD with mod-60 wrap, then issues a one-cycle load strobe with the new value, while centiseconds are reloaded to 00. It sits between the board KEY inputs and the clock counter chain, and also drives the display blink mask for the field being edited.

## Interface
- DEBOUNCE_CYC, 1_000_000: cycles a synchronized key must stay stable before it is accepted (20 ms at 50 MHz).
- BLINK_CYC, 12_500_000: half-period of the edit blink, in cycles.
- TIMEOUT_CYC, 500_000_000: idle cycles in an edit state before the edit is aborted (10 s).

- clk  in  1  system clock (CLOCK_50 domain).
- aclr  in  1  asynchronous reset, active-high.
- key_mode_n, key_inc_n, key_dec_n  in  1 each  raw buttons, active-low, asynchronous to clk.
- cur_min, cur_sec  in  7 each  running time, packed BCD {tens[6:4], units[3:0]}.
- set_min, set_sec  out  7 each  edited value, packed BCD; valid whenever load=1.
- load  out  1  one-cycle strobe; the clock loads set_min/set_sec and clears centiseconds.
- run_en  out  1  clock count enable; 0 while editing.
- editing  out  1  1 in SET_MIN or SET_SEC.
- hide  out  6  per-digit blank mask for HEX5..HEX0; bit=1 blanks that digit.

## Operation
- Key path: 2-flop synchronizer, then stability counter. Debounced level updates only after DEBOUNCE_CYC consecutive equal samples. Press event = one-cycle pulse on a debounced 1→0 transition. Release produces no event.
- FSM states: RUN, SET_MIN, SET_SEC, COMMIT.
  - RUN + mode: capture cur_min/cur_sec into the edit registers, then go to SET_MIN. Any captured digit pair that is not valid BCD ≤59 is replaced by 00.
  - SET_MIN + mode → SET_SEC.
  - SET_SEC + mode → COMMIT.
  - COMMIT → RUN unconditionally after 1 cycle, with load=1 during COMMIT.
  - In SET_MIN/SET_SEC, inc/dec events modify the active field only. inc: 59→00, otherwise +1 with BCD carry (09→10). dec: 00→59, otherwise −1 with BCD borrow (10→09).
  - In RUN, inc and dec events are ignored.
- Simultaneous events in the same cycle:
  - inc and dec together: both ignored.
  - mode together with inc/dec: mode wins and the field is unchanged.
- Timeout: an idle counter clears on any event. Reaching TIMEOUT_CYC in SET_MIN/SET_SEC returns the FSM to RUN with no load. set_min/set_sec keep the edited values, but they are not applied.
- Outputs:
  - run_en = 1 in RUN and COMMIT only.
  - editing = 1 in SET_MIN and SET_SEC.
  - Blink phase toggles every BLINK_CYC cycles while editing and is forced to 0 in RUN.
  - hide = 6'b110000 in SET_MIN with phase=1, 6'b001100 in SET_SEC with phase=1, and 0 otherwise.
- Reset values: state=RUN, load=0, run_en=1, editing=0, hide=0, set_min=set_sec=7'h00, debounced keys=1 (released), all counters 0.
- aclr asserted mid-edit or during COMMIT: immediate return to reset values. No load pulse is issued or completed.

## Timing
- Key press to event: 2 synchronizer cycles + DEBOUNCE_CYC cycles + 1 cycle.
- Mode event in SET_SEC at cycle n: state=COMMIT and load=1 at cycle n+1; state=RUN and load=0 at cycle n+2.
- inc/dec event at cycle n: set_min/set_sec show the updated value at cycle n+1.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package rtc_pkg holds:
  - state encoding constants (RUN=2'd0, SET_MIN=2'd1, SET_SEC=2'd2, COMMIT=2'd3);
  - the packed-BCD width (7);
  - functions bcd60_inc/bcd60_dec.
- One sub-module, key_debounce (parameter DEBOUNCE_CYC; ports clk, aclr, key_n, press), instantiated three times.
- The top level contains the FSM, edit registers, idle timer and blink timer.

## Test plan
All scenarios use DEBOUNCE_CYC=4, BLINK_CYC=8 and TIMEOUT_CYC=200.

- Reset: assert aclr mid-stream, then release → state=RUN, run_en=1, load=0, hide=0, set_min=set_sec=00.
- Bounce: toggle key_inc_n every 2 cycles for 20 cycles in SET_MIN → no event and set_min unchanged. Then hold low for 10 cycles → exactly one +1.
- Full edit:
  - cur=12:34, press mode → set_min=12.
  - inc ×48 → 00 (wrap at 59).
  - mode, then dec once → set_sec=33.
  - mode → single load pulse with set_min=00, set_sec=33, then run_en=1.
- Wrap and carry: set_sec 09 +inc → 10; 10 +dec → 09; 00 +dec → 59.
- Timeout: enter SET_MIN and idle 200 cycles → RUN, no load pulse ever observed, run_en=1.
- Collisions and invalid capture:
  - inc and dec events in the same cycle → value unchanged.
  - mode with inc in the same cycle → state advances and value unchanged.
  - cur_sec=7'h6A captured → set_sec=00.
